// File: rtl/dds_pkg.sv
// Shared constants and quarter-wave table generator for the DDS core.
// The clock-recovery writer imports the register address constants from here.
package dds_pkg;

  localparam int ACC_W  = 27;
  localparam int OUT_W  = 10;
  localparam int LUT_AW = 8;

  localparam logic [4:0] DDS_A_FREQ  = 5'd0;
  localparam logic [4:0] DDS_A_PHASE = 5'd16;

  typedef struct packed {
    logic [1:0] q;
    logic [LUT_AW-1:0] j;
  } dds_phase_t;

  // Table entry m = round(amp*cos(2*pi*m/(4*2^aw))), evaluated at elaboration.
  function automatic int lut_val(int m, int aw, int amp);
    real x, t, s;
    x = 3.14159265358979323846 * real'(m) / real'(1 << (aw + 1));
    t = 1.0;
    s = 1.0;
    for (int n = 1; n < 24; n++) begin
      t = -t * x * x / real'((2 * n - 1) * (2 * n));
      s = s + t;
    end
    return $rtoi(real'(amp) * s + 0.5);
  endfunction

endpackage

// File: rtl/dds_quarter_lut.sv
// Quarter-wave cosine table with two registered read ports: T[j] and T[2^AW-j].
module dds_quarter_lut
  import dds_pkg::*;
#(
  parameter int AW = 8,
  parameter int TW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] j,
  output logic [TW-1:0] t_j,
  output logic [TW-1:0] t_nj
);

  localparam int N = (1 << AW) + 1;

  logic [TW-1:0] rom [N];

  for (genvar m = 0; m < N; m++) begin : g_rom
    localparam logic [TW-1:0] V = TW'(lut_val(m, AW, (1 << TW) - 1));
    assign rom[m] = V;
  end

  logic [AW:0] ij;
  logic [AW:0] inj;

  assign ij  = {1'b0, j};
  assign inj = (AW + 1)'(1 << AW) - ij;

  always_ff @(posedge clk) begin
    if (!reset) begin
      t_j  <= '0;
      t_nj <= '0;
    end else begin
      t_j  <= rom[ij];
      t_nj <= rom[inj];
    end
  end

endmodule

// File: rtl/dds_regif_core.sv
// NCO with register write port: phase accumulator, offset add,
// quarter-wave lookup and quadrant sign fold into cosine/sine.
module dds_regif_core #(
  parameter int ACC_W  = dds_pkg::ACC_W,
  parameter int OUT_W  = dds_pkg::OUT_W,
  parameter int LUT_AW = dds_pkg::LUT_AW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [4:0]              a,
  input  logic [ACC_W-1:0]        data,
  output logic signed [OUT_W-1:0] cosine,
  output logic signed [OUT_W-1:0] sine,
  output logic                    out_valid,
  output logic                    addr_err
);

  import dds_pkg::*;

  localparam int TW = OUT_W - 1;

  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] ofs;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] p1;
  logic [1:0]       q2;
  logic [1:0]       vsh;
  logic [TW-1:0]    tj;
  logic [TW-1:0]    tnj;

  logic [LUT_AW+1:0] k;
  logic [1:0]        q;
  logic [LUT_AW-1:0] j;

  assign k = p1[ACC_W-1 -: LUT_AW+2];
  assign q = k[LUT_AW+1:LUT_AW];
  assign j = k[LUT_AW-1:0];

  dds_quarter_lut #(
    .AW(LUT_AW),
    .TW(TW)
  ) u_lut (
    .clk  (clk),
    .reset(reset),
    .j    (j),
    .t_j  (tj),
    .t_nj (tnj)
  );

  logic signed [OUT_W-1:0] pj;
  logic signed [OUT_W-1:0] pnj;

  assign pj  = $signed({1'b0, tj});
  assign pnj = $signed({1'b0, tnj});

  always_ff @(posedge clk) begin
    if (!reset) begin
      inc       <= '0;
      ofs       <= '0;
      acc       <= '0;
      p1        <= '0;
      q2        <= '0;
      vsh       <= '0;
      cosine    <= '0;
      sine      <= '0;
      out_valid <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      acc       <= acc + inc;
      p1        <= acc + ofs;
      q2        <= q;
      vsh       <= {vsh[0], 1'b1};
      out_valid <= vsh[1];
      if (we) begin
        unique case (1'b1)
          (a == DDS_A_FREQ):  inc <= data;
          (a == DDS_A_PHASE): ofs <= data;
          default:            addr_err <= 1'b1;
        endcase
      end
      case (q2)
        2'd0: begin
          cosine <= pj;
          sine   <= pnj;
        end
        2'd1: begin
          cosine <= -pnj;
          sine   <= pj;
        end
        2'd2: begin
          cosine <= -pj;
          sine   <= -pnj;
        end
        default: begin
          cosine <= pnj;
          sine   <= -pj;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_regif_core.sv
// Randomised bench: trig-formula reference model plus literal pins.
module tb_dds_regif_core;

  localparam longint MASK = (64'd1 << 27) - 1;
  localparam real     PI  = 3.14159265358979323846;

  logic              clk;
  logic              reset;
  logic              we;
  logic [4:0]        a;
  logic [26:0]       data;
  logic signed [9:0] cosine;
  logic signed [9:0] sine;
  logic              out_valid;
  logic              addr_err;

  dds_regif_core dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .a        (a),
    .data     (data),
    .cosine   (cosine),
    .sine     (sine),
    .out_valid(out_valid),
    .addr_err (addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic int ref_cos(input int k);
    return rnd(511.0 * $cos(2.0 * PI * real'(k) / 1024.0));
  endfunction

  function automatic int ref_sin(input int k);
    return rnd(511.0 * $sin(2.0 * PI * real'(k) / 1024.0));
  endfunction

  // Reference model: outputs follow the phase p1 two edges back.
  longint m_inc, m_ofs, m_acc, m_p1;
  int     m_k;
  bit     m_s2z;
  int     m_vcnt;
  int     e_cos, e_sin;
  bit     e_err;

  always @(posedge clk) begin
    if (!reset) begin
      m_inc  = 0;
      m_ofs  = 0;
      m_acc  = 0;
      m_p1   = 0;
      m_k    = 0;
      m_s2z  = 1'b1;
      m_vcnt = 0;
      e_cos  = 0;
      e_sin  = 0;
      e_err  = 1'b0;
    end else begin
      e_cos = m_s2z ? 0 : ref_cos(m_k);
      e_sin = m_s2z ? 0 : ref_sin(m_k);
      m_k   = int'(m_p1 >> 17);
      m_s2z = 1'b0;
      m_p1  = (m_acc + m_ofs) & MASK;
      m_acc = (m_acc + m_inc) & MASK;
      if (we) begin
        if (a == 5'd0) m_inc = longint'(data);
        else if (a == 5'd16) m_ofs = longint'(data);
        else e_err = 1'b1;
      end
      if (m_vcnt < 3) m_vcnt++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cosine", int'(cosine), e_cos);
      check("sine", int'(sine), e_sin);
      check("out_valid", int'(out_valid), int'(m_vcnt == 3));
      check("addr_err", int'(addr_err), int'(e_err));
    end
  end

  task automatic wr(input logic [4:0] ad, input longint d);
    we   = 1'b1;
    a    = ad;
    data = 27'(d);
    @(negedge clk);
    we   = 1'b0;
  endtask

  int ec[4];
  int es[4];
  int r;

  initial begin
    ec = '{511, 0, -511, 0};
    es = '{0, 511, 0, -511};
    reset = 1'b0;
    we    = 1'b0;
    a     = '0;
    data  = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_valid", int'(out_valid), 1);
    check("idle_cos", int'(cosine), 511);
    check("idle_sin", int'(sine), 0);

    wr(5'd16, 64'd1 << 25);
    repeat (3) @(negedge clk);
    check("quarter_cos", int'(cosine), 0);
    check("quarter_sin", int'(sine), 511);

    wr(5'd16, 0);
    wr(5'd0, 64'd1 << 25);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      check("step_cos", int'(cosine), ec[i % 4]);
      check("step_sin", int'(sine), es[i % 4]);
      @(negedge clk);
    end

    wr(5'd0, (64'd1 << 27) - (64'd1 << 25));
    repeat (16) @(negedge clk);

    wr(5'd0, 64'd1 << 17);
    repeat (1100) @(negedge clk);

    wr(5'd3, 123);
    check("addr_err_set", int'(addr_err), 1);
    repeat (4) @(negedge clk);
    check("addr_err_hold", int'(addr_err), 1);

    for (int i = 0; i < 400; i++) begin
      r    = int'($urandom_range(0, 2));
      we   = ($urandom_range(0, 3) == 0);
      a    = (r == 0) ? 5'd0 : (r == 1) ? 5'd16 : 5'($urandom);
      data = 27'($urandom);
      @(negedge clk);
    end
    we = 1'b0;

    wr(5'd0, 64'd1 << 17);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cos", int'(cosine), 0);
    check("rst_sin", int'(sine), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_err", int'(addr_err), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("valid_low", int'(out_valid), 0);
    @(negedge clk);
    check("valid_rise", int'(out_valid), 1);
    check("post_rst_cos", int'(cosine), 511);
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dds_regif_core.md
# dds_regif_core

Numerically controlled oscillator that sits on the receiving end of the clock-recovery loop's DDS register write bus. Each `we` pulse loads either a 27-bit frequency increment or a 27-bit phase offset. The phase accumulator advances every `clk`, and the block emits 10-bit signed cosine and sine samples from a quarter-wave table. The loop controller drives it and feeds the cosine to the recovered-clock slicer.

## Interface
Parameters:
- `ACC_W`, 27: accumulator, increment and offset width.
- `OUT_W`, 10: signed output sample width.
- `LUT_AW`, 8: quarter-wave index width. The phase address is `LUT_AW+2` bits.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-low.
- `we`  in  1: register write strobe, single-cycle.
- `a`  in  5: register address. 5'b00000 = frequency increment; 5'b10000 = phase offset.
- `data`  in  `ACC_W`: write data, two's complement.
- `cosine`  out  `OUT_W`: signed cosine sample.
- `sine`  out  `OUT_W`: signed sine sample.
- `out_valid`  out  1: high once the pipeline holds post-reset data.
- `addr_err`  out  1: sticky. Set by `we` with any other address.

## Operation
Reset (`reset`=0 at a `clk` edge) clears the following:
- `inc`, `ofs`, `acc`, all pipeline registers: 0.
- `cosine`, `sine`: 0.
- `out_valid`, `addr_err`: 0.

Register writes:
- `we`=1, `a`=0 → `inc` <= `data`.
- `we`=1, `a`=16 → `ofs` <= `data`.
- `we`=1, any other `a` → no register change; `addr_err` <= 1.
- `we`=0 → `a` and `data` are ignored.

Phase path, per cycle when not in reset:
- `acc` <= `acc` + `inc`, mod 2^27. Uses the pre-write `inc`.
- The wrap is silent. A negative `inc` counts down.

Pipeline:
- Stage 1: `p1` <= `acc` + `ofs`, mod 2^27.
- Stage 2: phase address `k` = `p1[26:17]`. Quadrant `q` = `k[9:8]`, index `j` = `k[7:0]`. Register `q`, T[`j`] and T[256-`j`].
- Stage 3: apply signs and register `cosine` and `sine`:
  - `q`=0: cos = +T[j], sin = +T[256-j].
  - `q`=1: cos = −T[256-j], sin = +T[j].
  - `q`=2: cos = −T[j], sin = −T[256-j].
  - `q`=3: cos = +T[256-j], sin = −T[j].

Table:
- T[m] = round(511·cos(2πm/1024)) for m = 0..256.
- 257 entries, 9-bit unsigned. T[0]=511, T[256]=0.
- Output range is −511..+511; −512 never occurs.

## Timing
- A write at edge n changes `acc` first at edge n+1.
- `acc` value → `cosine`/`sine`: 3 edges (`p1`, table, output).
- A frequency write at edge n first affects the output at edge n+4.
- A phase-offset write at edge n affects `p1` at edge n+1 and the output at edge n+3.
- `out_valid` rises at the 3rd edge after `reset` deasserts and stays high until the next reset.
- Back-to-back writes (increment at n, offset at n+1) are both taken. There is no busy state.
- Reset asserted mid-stream clears everything on that edge. No partial samples are emitted afterwards.
- `addr_err` holds until reset.

## Structure
- Shared package `dds_pkg`:
  - `ACC_W`, `OUT_W`, `LUT_AW`.
  - Address constants `DDS_A_FREQ`=5'd0 and `DDS_A_PHASE`=5'd16.
  - The 257-entry table contents. The clock-recovery writer imports the same address constants.
- Sub-module `dds_quarter_lut`: dual-read (ports `j` and 256−`j`), registered-output table. Everything else stays in the top level.

## Test plan
- Reset, then `inc`=0, `ofs`=0 → after `out_valid`: `cosine`=511, `sine`=0, constant.
- Write `ofs`=2^25 (quarter turn), `inc`=0 → `cosine`=0, `sine`=511 from the 3rd edge after the write.
- Write `inc`=2^25 → `cosine` 511,0,−511,0 repeating; `sine` 0,511,0,−511 repeating. The first new step appears 4 edges after the write.
- Write `inc`=2^27−2^25 (negative quarter) → `cosine` 511,0,−511,0 and `sine` 0,−511,0,511. This confirms accumulator wrap and count-down.
- Write `inc`=2^17 → phase address steps by 1 per cycle, giving a 1024-cycle period. Check every sample against the T formula, including `j`=0 and `j`=255 at quadrant edges.
- Write `a`=5'd3 with `data`=123 → `inc`/`ofs` unchanged, `addr_err`=1. The flag stays set until reset. Asserting reset mid-sweep zeroes all outputs on that edge.
